// File: rtl/spi_slave_if.sv
// Signal bundle between the SPI slave core, its SPI master pins and the local host.
// The slave modport is the core's view; the master modport is the driving side.
interface spi_slave_if #(
   parameter int DATA_W = 8
);
   logic              SS;
   logic              SCLK;
   logic              MOSI;
   logic              MISO;
   logic              INT;
   logic [DATA_W-1:0] tx_data;
   logic              tx_load;
   logic              tx_ready;
   logic              tx_underrun;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              irq_set;
   logic              irq_clr;

   modport slave (
      input  SS, SCLK, MOSI, tx_data, tx_load, irq_set, irq_clr,
      output MISO, INT, tx_ready, tx_underrun, rx_data, rx_valid, busy
   );

   modport master (
      output SS, SCLK, MOSI, tx_data, tx_load, irq_set, irq_clr,
      input  MISO, INT, tx_ready, tx_underrun, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by clk_26 with synchronised SS/SCLK/MOSI,
// a one-deep TX holding register, a receive byte register and a sticky interrupt.
module spi_slave #(
   parameter int DATA_W = 8
) (
   input  logic        clk_26,
   input  logic        RESET,
   spi_slave_if.slave  bus
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_SETTLE,
      S_WAIT_HIGH,
      S_IDLE,
      S_ACTIVE
   } state_e;

   logic [2:0] ss_q;
   logic [2:0] sclk_q;
   logic [1:0] mosi_q;
   logic       ss_s;
   logic       ss_fall;
   logic       ss_rise;
   logic       sclk_rise;
   logic       sclk_fall;
   logic       mosi_s;

   state_e     state_q, state_d;
   logic [1:0] settle_q, settle_d;
   logic       frame_start;
   logic       frame_end;
   logic       selected;

   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              full_q, full_d;
   logic              udr_q, udr_d;
   logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rxv_q, rxv_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              int_q, int_d;
   logic              load_req;

   // Synchroniser stage: two flops per input, a third on SS/SCLK for edge detection.
   always_ff @(posedge clk_26) begin
      if (RESET) begin
         ss_q   <= 3'b111;
         sclk_q <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         ss_q   <= {ss_q[1:0], bus.SS};
         sclk_q <= {sclk_q[1:0], bus.SCLK};
         mosi_q <= {mosi_q[0], bus.MOSI};
      end
   end

   assign ss_s      = ss_q[1];
   assign ss_fall   = ss_q[2] & ~ss_q[1];
   assign ss_rise   = ~ss_q[2] & ss_q[1];
   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign mosi_s    = mosi_q[1];

   // Frame FSM: state register.
   always_ff @(posedge clk_26) begin
      if (RESET) begin
         state_q  <= S_SETTLE;
         settle_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // The reset synchroniser values would fake an SS fall if SS is already low, so the
   // FSM waits for the pipeline to flush and for SS to be seen high before arming.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         S_SETTLE: begin
            settle_d = settle_q + 2'd1;
            if (settle_q == 2'd2) state_d = S_WAIT_HIGH;
         end
         S_WAIT_HIGH: if (ss_s)    state_d = S_IDLE;
         S_IDLE:      if (ss_fall) state_d = S_ACTIVE;
         S_ACTIVE:    if (ss_rise) state_d = S_IDLE;
         default:                  state_d = S_SETTLE;
      endcase
   end

   always_comb begin
      frame_start = (state_q == S_IDLE) && ss_fall;
      frame_end   = (state_q == S_ACTIVE) && ss_rise;
      selected    = (state_q == S_ACTIVE) && !ss_s;
   end

   // Shifter loads happen at frame start and on the first SCLK fall after a full byte.
   assign load_req = frame_start | (selected & sclk_fall & done_q);

   always_comb begin
      tx_d   = tx_q;
      hold_d = hold_q;
      full_d = full_q;
      udr_d  = 1'b0;
      if (load_req) begin
         if (full_q) begin
            tx_d   = hold_q;
            full_d = 1'b0;
         end else begin
            tx_d  = '1;
            udr_d = 1'b1;
            if (bus.tx_load) begin
               hold_d = bus.tx_data;
               full_d = 1'b1;
            end
         end
      end else begin
         if (selected && sclk_fall) tx_d = {tx_q[DATA_W-2:0], 1'b1};
         if (bus.tx_load && !full_q) begin
            hold_d = bus.tx_data;
            full_d = 1'b1;
         end
      end
   end

   always_comb begin
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rxv_d      = 1'b0;
      cnt_d      = cnt_q;
      done_d     = done_q;
      if (selected && sclk_fall && done_q) done_d = 1'b0;
      if (frame_start) begin
         cnt_d      = '0;
         rx_shift_d = '0;
         done_d     = 1'b0;
      end else if (frame_end) begin
         cnt_d  = '0;
         done_d = 1'b0;
      end else if (selected && sclk_rise) begin
         rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
         cnt_d      = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_LAST) begin
            rx_data_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            rxv_d     = 1'b1;
            done_d    = 1'b1;
         end
      end
   end

   // irq_set has priority over irq_clr.
   always_comb begin
      int_d = int_q;
      if (bus.irq_set)      int_d = 1'b1;
      else if (bus.irq_clr) int_d = 1'b0;
   end

   always_ff @(posedge clk_26) begin
      if (RESET) begin
         tx_q       <= '1;
         full_q     <= 1'b0;
         udr_q      <= 1'b0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rxv_q      <= 1'b0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         int_q      <= 1'b0;
      end else begin
         tx_q       <= tx_d;
         full_q     <= full_d;
         udr_q      <= udr_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rxv_q      <= rxv_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         int_q      <= int_d;
      end
   end

   // Holding data is only meaningful while full_q is set, so it carries no reset.
   always_ff @(posedge clk_26) begin
      hold_q <= hold_d;
   end

   assign bus.MISO        = ss_s ? 1'b1 : tx_q[DATA_W-1];
   assign bus.INT         = int_q;
   assign bus.tx_ready    = ~full_q;
   assign bus.tx_underrun = udr_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rxv_q;
   assign bus.busy        = ~ss_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master at clk_26/8 plus host-side strobes,
// checked against hand-computed bytes and pulse counts.
module tb_spi_slave;

   logic clk_26 = 1'b0;
   logic RESET;

   spi_slave_if #(.DATA_W(8)) ifc ();

   spi_slave #(.DATA_W(8)) dut (
      .clk_26 (clk_26),
      .RESET  (RESET),
      .bus    (ifc)
   );

   always #5 clk_26 = ~clk_26;

   int n_checks = 0;
   int n_fail   = 0;
   int rxv_cnt  = 0;
   int udr_cnt  = 0;
   logic [7:0] rx_log [0:15];

   // Pulse monitors, sampled on the inactive edge.
   always @(negedge clk_26) begin
      if (ifc.rx_valid === 1'b1) begin
         rx_log[rxv_cnt % 16] <= ifc.rx_data;
         rxv_cnt <= rxv_cnt + 1;
      end
      if (ifc.tx_underrun === 1'b1) udr_cnt <= udr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_26);
   endtask

   // Master side: MOSI set and MISO sampled half a period before each SCLK rise.
   // With last set, SCLK stays high after the final rise so end_frame raises SS first.
   task automatic send_bits(input logic [7:0] b, input int nbits, input bit last,
                            output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         ifc.MOSI = b[i];
         tick(4);
         miso[i]  = ifc.MISO;
         ifc.SCLK = 1'b1;
         tick(4);
         if (!(last && i == 8 - nbits)) ifc.SCLK = 1'b0;
      end
   endtask

   task automatic start_frame;
      ifc.SS = 1'b0;
      tick(6);
   endtask

   task automatic end_frame;
      ifc.SS = 1'b1;
      tick(4);
      ifc.SCLK = 1'b0;
      tick(6);
   endtask

   task automatic host_load(input logic [7:0] d);
      ifc.tx_data = d;
      ifc.tx_load = 1'b1;
      tick(1);
      ifc.tx_load = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] m0, m1;
      int rx0, ud0;
      bit seen;

      RESET       = 1'b1;
      ifc.SS      = 1'b1;
      ifc.SCLK    = 1'b0;
      ifc.MOSI    = 1'b0;
      ifc.tx_data = 8'h00;
      ifc.tx_load = 1'b0;
      ifc.irq_set = 1'b0;
      ifc.irq_clr = 1'b0;
      tick(3);
      RESET = 1'b0;
      tick(1);

      chk("rst_miso",     ifc.MISO,        1);
      chk("rst_int",      ifc.INT,         0);
      chk("rst_tx_ready", ifc.tx_ready,    1);
      chk("rst_underrun", ifc.tx_underrun, 0);
      chk("rst_rx_valid", ifc.rx_valid,    0);
      chk("rst_rx_data",  ifc.rx_data,     8'h00);
      chk("rst_busy",     ifc.busy,        0);
      tick(4);

      // Single byte
      rx0 = rxv_cnt; ud0 = udr_cnt;
      host_load(8'hA5);
      chk("single_ready_low", ifc.tx_ready, 0);
      start_frame();
      chk("single_busy",      ifc.busy,     1);
      chk("single_ready_ret", ifc.tx_ready, 1);
      send_bits(8'h3C, 8, 1'b1, m0);
      end_frame();
      chk("single_miso",     m0,              8'hA5);
      chk("single_rx_data",  ifc.rx_data,     8'h3C);
      chk("single_rxv_cnt",  rxv_cnt - rx0,   1);
      chk("single_no_udr",   udr_cnt - ud0,   0);
      chk("single_ready",    ifc.tx_ready,    1);
      chk("single_miso_idle", ifc.MISO,       1);
      chk("single_busy_off", ifc.busy,        0);

      // Back-to-back in one frame with a reload after the first shifter load
      rx0 = rxv_cnt; ud0 = udr_cnt;
      host_load(8'h11);
      ifc.SS = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick(1);
         if (ifc.tx_ready === 1'b1) seen = 1'b1;
      end
      chk("b2b_ready_wait", seen, 1);
      host_load(8'h22);
      tick(4);
      send_bits(8'hF0, 8, 1'b0, m0);
      send_bits(8'h0F, 8, 1'b1, m1);
      end_frame();
      chk("b2b_miso0",   m0, 8'h11);
      chk("b2b_miso1",   m1, 8'h22);
      chk("b2b_rxv_cnt", rxv_cnt - rx0, 2);
      chk("b2b_rx0",     rx_log[rx0 % 16], 8'hF0);
      chk("b2b_rx1",     rx_log[(rx0 + 1) % 16], 8'h0F);
      chk("b2b_no_udr",  udr_cnt - ud0, 0);

      // Underrun
      rx0 = rxv_cnt; ud0 = udr_cnt;
      start_frame();
      send_bits(8'h96, 8, 1'b1, m0);
      end_frame();
      chk("udr_miso",    m0, 8'hFF);
      chk("udr_pulses",  udr_cnt - ud0, 1);
      chk("udr_rxv_cnt", rxv_cnt - rx0, 1);
      chk("udr_rx_data", ifc.rx_data, 8'h96);

      // Abort after five rising edges, then a clean frame
      rx0 = rxv_cnt;
      start_frame();
      send_bits(8'hB6, 5, 1'b1, m0);
      end_frame();
      chk("abort_no_rxv", rxv_cnt - rx0, 0);
      chk("abort_miso",   ifc.MISO, 1);
      chk("abort_rx_hold", ifc.rx_data, 8'h96);
      start_frame();
      send_bits(8'hC3, 8, 1'b1, m0);
      end_frame();
      chk("abort_next_rxv", rxv_cnt - rx0, 1);
      chk("abort_next_rx",  ifc.rx_data, 8'hC3);

      // tx_load coinciding with a load from an empty holding register
      ud0 = udr_cnt;
      ifc.SS = 1'b0;
      tick(2);
      host_load(8'hE7);
      tick(3);
      send_bits(8'h00, 8, 1'b1, m0);
      end_frame();
      chk("coinc_miso",  m0, 8'hFF);
      chk("coinc_udr",   udr_cnt - ud0, 1);
      chk("coinc_ready", ifc.tx_ready, 0);
      ud0 = udr_cnt;
      start_frame();
      send_bits(8'h5A, 8, 1'b1, m0);
      end_frame();
      chk("coinc_next_miso", m0, 8'hE7);
      chk("coinc_next_udr",  udr_cnt - ud0, 0);

      // Overwrite guard
      host_load(8'h55);
      host_load(8'hAA);
      chk("ovw_ready", ifc.tx_ready, 0);
      start_frame();
      send_bits(8'h00, 8, 1'b1, m0);
      end_frame();
      chk("ovw_miso", m0, 8'h55);

      // Reset mid-transfer: the rest of that select is ignored
      rx0 = rxv_cnt;
      start_frame();
      send_bits(8'hFF, 3, 1'b0, m0);
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      send_bits(8'h81, 8, 1'b1, m1);
      chk("rstmid_miso", m1, 8'hFF);
      end_frame();
      chk("rstmid_no_rxv", rxv_cnt - rx0, 0);
      chk("rstmid_rx_clr", ifc.rx_data, 8'h00);
      start_frame();
      send_bits(8'h7E, 8, 1'b1, m0);
      end_frame();
      chk("rstmid_next_rx", ifc.rx_data, 8'h7E);
      chk("rstmid_next_rxv", rxv_cnt - rx0, 1);

      // Interrupt
      ifc.irq_set = 1'b1;
      ifc.irq_clr = 1'b1;
      tick(1);
      ifc.irq_set = 1'b0;
      ifc.irq_clr = 1'b0;
      chk("int_both", ifc.INT, 1);
      tick(2);
      chk("int_sticky", ifc.INT, 1);
      ifc.irq_clr = 1'b1;
      tick(1);
      ifc.irq_clr = 1'b0;
      chk("int_clr", ifc.INT, 0);
      ifc.irq_set = 1'b1;
      tick(1);
      ifc.irq_set = 1'b0;
      chk("int_set", ifc.INT, 1);
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      chk("int_reset", ifc.INT, 0);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
